// File: rtl/sw_pkg.sv
// Shared switch types: flit type encoding and the per-port control state.
package sw_pkg;

  typedef enum logic [1:0] {
    FT_NONE = 2'b00,
    FT_HEAD = 2'b01,
    FT_BODY = 2'b10,
    FT_TAIL = 2'b11
  } flit_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_AREQ  = 2'b01,
    ST_XFER  = 2'b10,
    ST_DRAIN = 2'b11
  } port_state_t;

  // Width of an index into n items; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin priority picker: the first valid entry after ptr_i wins,
// wrapping around, so ptr_i itself has the lowest priority.
module rr_pick
  import sw_pkg::*;
#(
  parameter  int N  = 2,
  localparam int IW = idx_w(N)
) (
  input  logic [N-1:0]  valid_i,
  input  logic [IW-1:0] ptr_i,
  output logic          hit_o,
  output logic [IW-1:0] idx_o
);

  logic [IW-1:0] cand;

  // Walk from lowest to highest priority so the last match is the winner.
  always_comb begin
    hit_o = 1'b0;
    idx_o = '0;
    cand  = '0;
    for (int k = N; k >= 1; k--) begin
      cand = IW'((int'(ptr_i) + k) % N);
      if (valid_i[cand]) begin
        hit_o = 1'b1;
        idx_o = cand;
      end
    end
  end

endmodule

// File: rtl/vc_input_mgr.sv
// Input-port buffer manager: picks a VC round-robin, requests the routed
// output, drains the packet under backpressure, and discards malformed or
// oversize packets.
module vc_input_mgr
  import sw_pkg::*;
#(
  parameter  int NPORT  = 5,
  parameter  int NVC    = 2,
  parameter  int MAXLEN = 64,
  localparam int SW     = idx_w(NVC)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  flit_t [NVC-1:0]            vc_type,
  input  logic  [NVC-1:0]            vc_empty,
  input  logic  [NVC-1:0][NPORT-1:0] vc_dest,
  output logic  [NVC-1:0]            vc_re,
  output logic  [NPORT-1:0]          req,
  input  logic                       ack,
  input  logic                       stall,
  output logic  [SW-1:0]             sel,
  output logic                       fwd,
  output logic                       drop,
  output logic                       err,
  output logic                       busy
);

  localparam int            CW      = (MAXLEN > 0) ? $clog2(MAXLEN + 1) : 1;
  localparam logic [SW-1:0] RR_INIT = SW'(NVC - 1);

  port_state_t      state_q, state_d;
  logic [SW-1:0]    sel_q, sel_d;
  logic [SW-1:0]    rr_q, rr_d;
  logic [NPORT-1:0] dest_q, dest_d;
  logic [CW-1:0]    cnt_q, cnt_d, cnt_inc;

  logic             pick_hit;
  logic [SW-1:0]    pick_idx;
  logic [NPORT-1:0] pick_dest;
  logic             pick_ok;
  logic             len_hit;
  logic             rd;
  flit_t            cur_type;

  rr_pick #(.N(NVC)) u_pick (
    .valid_i (~vc_empty),
    .ptr_i   (rr_q),
    .hit_o   (pick_hit),
    .idx_o   (pick_idx)
  );

  assign pick_dest = vc_dest[pick_idx];
  // A packet may only be requested if it starts with a head and routes to exactly one port.
  assign pick_ok   = (vc_type[pick_idx] == FT_HEAD) && (pick_dest != '0) &&
                     ((pick_dest & (pick_dest - NPORT'(1))) == '0);
  assign cur_type  = vc_type[sel_q];
  assign cnt_inc   = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + CW'(1);
  assign len_hit   = (MAXLEN != 0) && (int'(cnt_inc) >= MAXLEN);

  assign sel  = sel_q;
  assign busy = (state_q != ST_IDLE);

  // Next-state, read decode and per-flit policing.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    rr_d    = rr_q;
    dest_d  = dest_q;
    cnt_d   = cnt_q;
    vc_re   = '0;
    req     = '0;
    fwd     = 1'b0;
    drop    = 1'b0;
    err     = 1'b0;
    rd      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pick_hit) begin
          sel_d  = pick_idx;
          dest_d = pick_dest;
          if (pick_ok) begin
            state_d = ST_AREQ;
          end else begin
            state_d = ST_DRAIN;
            err     = 1'b1;
          end
        end
      end
      ST_AREQ: begin
        req = dest_q;
        rd  = ack & ~stall & ~vc_empty[sel_q];
        if (ack) state_d = ST_XFER;
      end
      ST_XFER: begin
        req = dest_q;
        rd  = ~stall & ~vc_empty[sel_q];
      end
      ST_DRAIN: begin
        // Discarded flits go nowhere, so backpressure does not apply.
        rd = ~vc_empty[sel_q];
      end
      default: state_d = ST_IDLE;
    endcase

    if (rd) begin
      vc_re[sel_q] = 1'b1;
      if (state_q == ST_DRAIN) begin
        drop = 1'b1;
        if (cur_type == FT_TAIL) begin
          state_d = ST_IDLE;
          rr_d    = sel_q;
          cnt_d   = '0;
        end
      end else begin
        fwd   = 1'b1;
        cnt_d = cnt_inc;
        // A head after the first flit is a framing error but still forwarded.
        if (cur_type == FT_HEAD && cnt_q != '0) err = 1'b1;
        if (cur_type == FT_TAIL) begin
          state_d = ST_IDLE;
          rr_d    = sel_q;
          cnt_d   = '0;
        end else if (len_hit) begin
          err     = 1'b1;
          state_d = ST_DRAIN;
        end
      end
    end

    // No FIFO pops or pulses while reset is held.
    if (rst) begin
      vc_re = '0;
      fwd   = 1'b0;
      drop  = 1'b0;
      err   = 1'b0;
    end
  end

  // State and bookkeeping registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      rr_q    <= RR_INIT;
      dest_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      rr_q    <= rr_d;
      dest_q  <= dest_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
